alu_control_fsm: RTL and testbench

Multi-cycle issue/control unit that drives the 32-bit ALU in the MIPS32 datapath. It accepts one decoded-field instruction over a valid/ready handshake and translates opcode/funct into the 4-bit ALU operation code. It selects the ALU operands (register or extended immediate), captures the ALU result and returns the result plus zero/branch flags over a second valid/ready handshake. It sits between the instruction-decode stage and the ALU/write-back logic.

---
 rtl/alu_control_fsm.sv | 158 +++++++++++++++
 tb/tb_alu_control_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_fsm.sv
// Multi-cycle issue/control unit for the MIPS32 ALU: it decodes opcode/funct into an
// ALU operation code, selects the operands, then captures the result and its flags.
module alu_control_fsm #(
  parameter int SIZEDATA = 32,
  parameter int OP       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  output logic                ready_out,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic [SIZEDATA-1:0] rs_dato,
  input  logic [SIZEDATA-1:0] rt_dato,
  input  logic [15:0]         imm,
  output logic [OP-1:0]       operador,
  output logic [SIZEDATA-1:0] a,
  output logic [SIZEDATA-1:0] b,
  input  logic [SIZEDATA-1:0] resultado,
  output logic                valid_out,
  input  logic                ready_in,
  output logic [SIZEDATA-1:0] resultado_out,
  output logic                cero,
  output logic                branch_tomado,
  output logic                error
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, DONE} state_t;

  localparam logic [OP-1:0] ALU_AND = OP'(4'b0000);
  localparam logic [OP-1:0] ALU_OR  = OP'(4'b0001);
  localparam logic [OP-1:0] ALU_ADD = OP'(4'b0010);
  localparam logic [OP-1:0] ALU_SUB = OP'(4'b0110);
  localparam logic [OP-1:0] ALU_SLT = OP'(4'b0111);
  localparam logic [OP-1:0] ALU_NOR = OP'(4'b1100);

  state_t              state;
  logic [5:0]          opcode_q;
  logic [5:0]          funct_q;
  logic [SIZEDATA-1:0] rs_q;
  logic [SIZEDATA-1:0] rt_q;
  logic [15:0]         imm_q;
  logic                err_q;
  logic                beq_q;

  logic [OP-1:0]       dec_op;
  logic [SIZEDATA-1:0] dec_b;
  logic                dec_err;
  logic [SIZEDATA-1:0] imm_sext;
  logic [SIZEDATA-1:0] imm_zext;

  assign imm_sext = {{(SIZEDATA-16){imm_q[15]}}, imm_q};
  assign imm_zext = {{(SIZEDATA-16){1'b0}}, imm_q};

  // Handshake strobes are pure decodes of the state register, so reset drives them at once.
  assign ready_out = (state == IDLE);
  assign valid_out = (state == DONE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    dec_op  = ALU_AND;
    dec_b   = '0;
    dec_err = 1'b0;
    unique case (opcode_q)
      6'b000000: begin
        dec_b = rt_q;
        unique case (funct_q)
          6'b100100: dec_op = ALU_AND;
          6'b100101: dec_op = ALU_OR;
          6'b100000: dec_op = ALU_ADD;
          6'b100010: dec_op = ALU_SUB;
          6'b101010: dec_op = ALU_SLT;
          6'b100111: dec_op = ALU_NOR;
          default: begin
            dec_b   = '0;
            dec_err = 1'b1;
          end
        endcase
      end
      6'b001000, 6'b100011, 6'b101011: begin
        dec_op = ALU_ADD;
        dec_b  = imm_sext;
      end
      6'b001010: begin
        dec_op = ALU_SLT;
        dec_b  = imm_sext;
      end
      6'b001100: begin
        dec_op = ALU_AND;
        dec_b  = imm_zext;
      end
      6'b001101: begin
        dec_op = ALU_OR;
        dec_b  = imm_zext;
      end
      6'b000100: begin
        dec_op = ALU_SUB;
        dec_b  = rt_q;
      end
      default: dec_err = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      opcode_q      <= '0;
      funct_q       <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      imm_q         <= '0;
      err_q         <= 1'b0;
      beq_q         <= 1'b0;
      operador      <= '0;
      a             <= '0;
      b             <= '0;
      resultado_out <= '0;
      cero          <= 1'b0;
      branch_tomado <= 1'b0;
      error         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_in) begin
            opcode_q <= opcode;
            funct_q  <= funct;
            rs_q     <= rs_dato;
            rt_q     <= rt_dato;
            imm_q    <= imm;
            state    <= DECODE;
          end
        end
        DECODE: begin
          operador <= dec_op;
          a        <= rs_q;
          b        <= dec_b;
          err_q    <= dec_err;
          beq_q    <= (opcode_q == 6'b000100);
          state    <= EXEC;
        end
        EXEC: begin
          // Zero is derived from the captured result, not from any ALU zero output.
          resultado_out <= resultado;
          cero          <= (resultado == '0);
          branch_tomado <= beq_q && (resultado == '0);
          error         <= err_q;
          state         <= DONE;
        end
        DONE: begin
          if (ready_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_fsm.sv
// Self-checking bench for alu_control_fsm: directed cases plus random instructions
// compared with an instruction-level reference model and a behavioural ALU.
module tb_alu_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_dato;
  logic [31:0] rt_dato;
  logic [15:0] imm;
  logic [3:0]  operador;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] resultado;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] resultado_out;
  logic        cero;
  logic        branch_tomado;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  alu_control_fsm #(.SIZEDATA(32), .OP(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .opcode(opcode), .funct(funct), .rs_dato(rs_dato), .rt_dato(rt_dato), .imm(imm),
    .operador(operador), .a(a), .b(b), .resultado(resultado),
    .valid_out(valid_out), .ready_in(ready_in), .resultado_out(resultado_out),
    .cero(cero), .branch_tomado(branch_tomado), .error(error)
  );

  always #5 clk = ~clk;

  // Behavioural ALU sitting after the control unit.
  always_comb begin
    resultado = '0;
    case (operador)
      4'b0000: resultado = a & b;
      4'b0001: resultado = a | b;
      4'b0010: resultado = a + b;
      4'b0110: resultado = a - b;
      4'b0111: resultado = {31'b0, $signed(a) < $signed(b)};
      4'b1100: resultado = ~(a | b);
      default: resultado = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction-level model: what the instruction means, not how the FSM gets there.
  task automatic ref_model(input logic [5:0] opc, input logic [5:0] fn,
                           input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im,
                           output logic [3:0] e_op, output logic [31:0] e_b,
                           output logic [31:0] e_res, output logic e_err, output logic e_beq);
    logic [31:0] sx;
    logic [31:0] zx;
    sx    = 32'($signed(im));
    zx    = 32'(im);
    e_op  = 4'b0000;
    e_b   = 32'h0;
    e_err = 1'b0;
    e_beq = 1'b0;
    if (opc == 6'b000000 && fn == 6'b100100)      begin e_op = 4'b0000; e_b = rt; e_res = rs & rt; end
    else if (opc == 6'b000000 && fn == 6'b100101) begin e_op = 4'b0001; e_b = rt; e_res = rs | rt; end
    else if (opc == 6'b000000 && fn == 6'b100000) begin e_op = 4'b0010; e_b = rt; e_res = rs + rt; end
    else if (opc == 6'b000000 && fn == 6'b100010) begin e_op = 4'b0110; e_b = rt; e_res = rs - rt; end
    else if (opc == 6'b000000 && fn == 6'b101010) begin
      e_op = 4'b0111; e_b = rt; e_res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
    end
    else if (opc == 6'b000000 && fn == 6'b100111) begin e_op = 4'b1100; e_b = rt; e_res = ~(rs | rt); end
    else if (opc == 6'b001000 || opc == 6'b100011 || opc == 6'b101011) begin
      e_op = 4'b0010; e_b = sx; e_res = rs + sx;
    end
    else if (opc == 6'b001010) begin
      e_op = 4'b0111; e_b = sx; e_res = ($signed(rs) < $signed(sx)) ? 32'd1 : 32'd0;
    end
    else if (opc == 6'b001100) begin e_op = 4'b0000; e_b = zx; e_res = rs & zx; end
    else if (opc == 6'b001101) begin e_op = 4'b0001; e_b = zx; e_res = rs | zx; end
    else if (opc == 6'b000100) begin e_op = 4'b0110; e_b = rt; e_res = rs - rt; e_beq = 1'b1; end
    else begin e_err = 1'b1; e_res = 32'h0; end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 10 && !ready_out; i++) @(negedge clk);
    check("ready_wait", 32'(ready_out), 32'd1);
  endtask

  // Issue one instruction and follow it to the end of the result handshake.
  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input logic [15:0] im, input int stall);
    logic [3:0]  e_op;
    logic [31:0] e_b, e_res;
    logic        e_err, e_beq, e_cero;
    ref_model(opc, fn, rs, rt, im, e_op, e_b, e_res, e_err, e_beq);
    e_cero = (e_res == 32'h0);
    wait_ready();
    opcode = opc; funct = fn; rs_dato = rs; rt_dato = rt; imm = im;
    valid_in = 1'b1;
    ready_in = (stall == 0);
    @(negedge clk);
    check("accept_ready_low", 32'(ready_out), 32'd0);
    check("accept_valid_low", 32'(valid_out), 32'd0);
    // Scramble fields while busy; they must have no effect.
    opcode = 6'($urandom); funct = 6'($urandom); rs_dato = $urandom; rt_dato = $urandom;
    imm = 16'($urandom);
    @(negedge clk);
    check("operador", 32'(operador), 32'(e_op));
    check("a", a, rs);
    check("b", b, e_b);
    check("decode_valid_low", 32'(valid_out), 32'd0);
    @(negedge clk);
    check("valid_out", 32'(valid_out), 32'd1);
    check("resultado_out", resultado_out, e_res);
    check("cero", 32'(cero), 32'(e_cero));
    check("branch_tomado", 32'(branch_tomado), 32'(e_beq && e_cero));
    check("error", 32'(error), 32'(e_err));
    check("done_ready_low", 32'(ready_out), 32'd0);
    for (int i = 1; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(valid_out), 32'd1);
      check("stall_result", resultado_out, e_res);
      check("stall_error", 32'(error), 32'(e_err));
      check("stall_operador", 32'(operador), 32'(e_op));
      check("stall_ready_low", 32'(ready_out), 32'd0);
    end
    ready_in = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    check("release_valid_low", 32'(valid_out), 32'd0);
    check("release_ready_high", 32'(ready_out), 32'd1);
    check("hold_operador", 32'(operador), 32'(e_op));
  endtask

  localparam int NLEGAL = 13;
  logic [5:0] legal_opc [NLEGAL] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                    6'b001000, 6'b001010, 6'b001100, 6'b001101,
                                    6'b100011, 6'b101011, 6'b000100};
  logic [5:0] legal_fn  [NLEGAL] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010,
                                    6'b101010, 6'b100111, 6'h00, 6'h00, 6'h00, 6'h00,
                                    6'h00, 6'h00, 6'h00};

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    opcode = '0; funct = '0; rs_dato = '0; rt_dato = '0; imm = '0;
    #1;
    check("rst_ready_out", 32'(ready_out), 32'd1);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_operador", 32'(operador), 32'd0);
    check("rst_a", a, 32'd0);
    check("rst_b", b, 32'd0);
    check("rst_resultado_out", resultado_out, 32'd0);
    check("rst_flags", {29'd0, cero, branch_tomado, error}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_instr(6'b000000, 6'b100000, 32'h7FFF_FFFF, 32'h1, 16'h0, 0);
    run_instr(6'b001000, 6'h00, 32'd5, 32'h0, 16'hFFFB, 0);
    run_instr(6'b001100, 6'h00, 32'hFFFF_FFFF, 32'h0, 16'h8001, 0);
    run_instr(6'b000100, 6'h00, 32'h1234, 32'h1234, 16'h0, 0);
    run_instr(6'b000100, 6'h00, 32'h1234, 32'h1235, 16'h0, 0);
    run_instr(6'b000000, 6'b000111, 32'hDEAD_BEEF, 32'h1234_5678, 16'h0, 5);

    // Reset in the middle of EXEC aborts the instruction with no result pulse.
    wait_ready();
    opcode = 6'b000000; funct = 6'b100101; rs_dato = 32'hF0F0_0000; rt_dato = 32'h0000_0F0F;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready_out", 32'(ready_out), 32'd1);
    check("abort_valid_out", 32'(valid_out), 32'd0);
    check("abort_operador", 32'(operador), 32'd0);
    check("abort_a", a, 32'd0);
    check("abort_b", b, 32'd0);
    check("abort_resultado", resultado_out, 32'd0);
    check("abort_flags", {29'd0, cero, branch_tomado, error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_abort_no_valid", 32'(valid_out), 32'd0);
    end

    for (int t = 0; t < 40; t++) begin
      int          k;
      logic [5:0]  opc, fn;
      logic [31:0] rs, rt;
      logic [15:0] im;
      k  = int'($urandom_range(0, NLEGAL + 1));
      rs = $urandom; rt = $urandom; im = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rt = rs;
      if (k < NLEGAL) begin
        opc = legal_opc[k]; fn = legal_fn[k];
      end else if (k == NLEGAL) begin
        opc = 6'b000000; fn = 6'b000011;
      end else begin
        opc = 6'b111111; fn = 6'($urandom);
      end
      run_instr(opc, fn, rs, rt, im, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
